// File: rtl/ship_motion_unit.sv
// ship_motion_unit
//
// Asteroids-style ship kinematics. A 10-bit heading phase is turned into
// signed sine/cosine values through a quarter-wave ROM. Each thrust cycle adds
// a scaled copy of the heading vector to a saturating per-axis velocity. On
// every position tick the velocity is added to a fixed-point screen position
// that wraps at the screen edges.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; recentres the ship, clears
//              velocity, trig outputs and the tick counter
//   theta      heading phase, 0..1023 covers one full turn
//   B          thrust; every cycle it is high applies one thrust increment
//   collision  synchronous respawn: recentres the ship and clears velocity
//   sin_val    signed round(65536*sin(2*pi*theta/1024)), one cycle latency
//   cos_val    signed round(65536*cos(2*pi*theta/1024)), one cycle latency
//   topLeft_x  integer part of the x position, 0..WIDTH-1
//   topLeft_y  integer part of the y position, 0..HEIGHT-1

module ship_motion_unit #(
    parameter int CLK_RATE     = 50000000,
    parameter int DIVIDER      = 60,
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int FRAC         = 8,
    parameter int THRUST_SHIFT = 10,
    parameter int MAX_V        = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                theta,
    input  logic                      B,
    input  logic                      collision,
    output logic [17:0]               sin_val,
    output logic [17:0]               cos_val,
    output logic [$clog2(WIDTH)-1:0]  topLeft_x,
    output logic [$clog2(HEIGHT)-1:0] topLeft_y
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int XW = $clog2(WIDTH) + FRAC;   // x position width
    localparam int YW = $clog2(HEIGHT) + FRAC;  // y position width

    localparam int TICK_RAW    = CLK_RATE / DIVIDER;
    localparam int TICK_PERIOD = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int CNT_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

    localparam logic [XW-1:0] X_HOME = XW'((WIDTH / 2) << FRAC);
    localparam logic [YW-1:0] Y_HOME = YW'((HEIGHT / 2) << FRAC);

    // Position sums carry two spare bits: one for a sign, one for overshoot
    // past the screen span before wrapping.
    localparam logic signed [XW+1:0] X_SPAN = (XW + 2)'(WIDTH << FRAC);
    localparam logic signed [YW+1:0] Y_SPAN = (YW + 2)'(HEIGHT << FRAC);

    localparam logic signed [19:0] V_LIMIT = 20'(MAX_V);

    // pi in Q30 fixed point
    localparam longint PI_Q30 = 64'sd3373259426;

    // ------------------------------------------------------------------
    // Quarter-wave table, built at elaboration.
    // Entry i holds round(65536*sin(pi*i/512)) for i = 0..256, evaluated by
    // a Taylor series in Q30; the series error is far below one output LSB,
    // so both endpoints come out exact (0 and 65536).
    // ------------------------------------------------------------------
    function automatic logic [16:0] quarter_sin(input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (PI_Q30 * longint'(idx)) / 64'sd512;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return 17'((acc + 64'sd8192) >>> 14);
    endfunction

    // NOTE: the table is constant logic, not storage, so it has no reset.
    logic [16:0] rom [0:256];

    for (genvar g = 0; g <= 256; g++) begin : g_rom
        localparam logic [16:0] ROM_VAL = quarter_sin(g);
        assign rom[g] = ROM_VAL;
    end

    // ------------------------------------------------------------------
    // Quadrant folding: sin uses the direct entry in quadrants 0/2 and the
    // mirrored entry in 1/3; cos is the same wave shifted by a quarter turn.
    // ------------------------------------------------------------------
    logic [1:0]  quadrant;
    logic [7:0]  idx;
    logic [8:0]  idx_mirror;
    logic [16:0] mag_direct;
    logic [16:0] mag_mirror;
    logic [16:0] sin_mag;
    logic [16:0] cos_mag;
    logic        sin_neg;
    logic        cos_neg;
    logic [17:0] sin_next;
    logic [17:0] cos_next;

    assign quadrant   = theta[9:8];
    assign idx        = theta[7:0];
    assign idx_mirror = 9'd256 - {1'b0, idx};
    assign mag_direct = rom[{1'b0, idx}];
    assign mag_mirror = rom[idx_mirror];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        sin_mag = mag_direct;
        cos_mag = mag_mirror;
        sin_neg = 1'b0;
        cos_neg = 1'b0;
        case (quadrant)
            2'd0: begin
                sin_mag = mag_direct;
                cos_mag = mag_mirror;
            end
            2'd1: begin
                sin_mag = mag_mirror;
                cos_mag = mag_direct;
                cos_neg = 1'b1;
            end
            2'd2: begin
                sin_mag = mag_direct;
                cos_mag = mag_mirror;
                sin_neg = 1'b1;
                cos_neg = 1'b1;
            end
            default: begin
                sin_mag = mag_mirror;
                cos_mag = mag_direct;
                sin_neg = 1'b1;
            end
        endcase
    end

    assign sin_next = sin_neg ? -{1'b0, sin_mag} : {1'b0, sin_mag};
    assign cos_next = cos_neg ? -{1'b0, cos_mag} : {1'b0, cos_mag};

    // ------------------------------------------------------------------
    // Position tick: one-cycle pulse every TICK_PERIOD cycles
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == CNT_W'(TICK_PERIOD - 1));

    // ------------------------------------------------------------------
    // Velocity update (thrust uses the registered trig values)
    // ------------------------------------------------------------------
    logic signed [15:0] vx;
    logic signed [15:0] vy;
    logic signed [17:0] thrust_x;
    logic signed [17:0] thrust_y;
    logic signed [19:0] vx_sum;
    logic signed [19:0] vy_sum;

    assign thrust_x = $signed(cos_val) >>> THRUST_SHIFT;
    assign thrust_y = $signed(sin_val) >>> THRUST_SHIFT;

    // Screen y grows downward, so a positive sine moves the ship up.
    assign vx_sum = {{4{vx[15]}}, vx} + {{2{thrust_x[17]}}, thrust_x};
    assign vy_sum = {{4{vy[15]}}, vy} - {{2{thrust_y[17]}}, thrust_y};

    function automatic logic [15:0] saturate_v(input logic signed [19:0] v);
        if (v > V_LIMIT) begin
            return 16'(V_LIMIT);
        end else if (v < -V_LIMIT) begin
            return 16'(-V_LIMIT);
        end
        return v[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Position update with wrap; one correction suffices because the
    // velocity limit is far smaller than either screen dimension.
    // ------------------------------------------------------------------
    logic [XW-1:0]        xp;
    logic [YW-1:0]        yp;
    logic signed [XW+1:0] x_sum;
    logic signed [YW+1:0] y_sum;
    logic [XW-1:0]        xp_next;
    logic [YW-1:0]        yp_next;

    assign x_sum = {2'b00, xp} + {{(XW + 2 - 16){vx[15]}}, vx};
    assign y_sum = {2'b00, yp} + {{(YW + 2 - 16){vy[15]}}, vy};

    always_comb begin
        xp_next = x_sum[XW-1:0];
        if (x_sum >= X_SPAN) begin
            xp_next = XW'(x_sum - X_SPAN);
        end else if (x_sum < 0) begin
            xp_next = XW'(x_sum + X_SPAN);
        end
    end

    always_comb begin
        yp_next = y_sum[YW-1:0];
        if (y_sum >= Y_SPAN) begin
            yp_next = YW'(y_sum - Y_SPAN);
        end else if (y_sum < 0) begin
            yp_next = YW'(y_sum + Y_SPAN);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: state is written with <= so every register samples the values
    // that were present before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sin_val  <= '0;
            cos_val  <= '0;
            tick_cnt <= '0;
        end else begin
            sin_val  <= sin_next;
            cos_val  <= cos_next;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || collision) begin
            xp <= X_HOME;
            yp <= Y_HOME;
            vx <= '0;
            vy <= '0;
        end else begin
            if (B) begin
                vx <= saturate_v(vx_sum);
                vy <= saturate_v(vy_sum);
            end
            // x_sum/y_sum use the pre-thrust velocity of this cycle.
            if (tick) begin
                xp <= xp_next;
                yp <= yp_next;
            end
        end
    end

    assign topLeft_x = xp[XW-1:FRAC];
    assign topLeft_y = yp[YW-1:FRAC];

endmodule

// File: tb/tb_ship_motion_unit.sv
// tb_ship_motion_unit
//
// Directed bench for ship_motion_unit with a 2-cycle tick (CLK_RATE=4,
// DIVIDER=2). Edges are numbered from the last reset edge (edge 0); position
// ticks land on even edges. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.

module tb_ship_motion_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] theta;
    logic       B;
    logic       collision;
    logic [17:0] sin_val;
    logic [17:0] cos_val;
    logic [9:0]  topLeft_x;
    logic [8:0]  topLeft_y;

    always #5 clk = ~clk;

    ship_motion_unit #(
        .CLK_RATE    (4),
        .DIVIDER     (2),
        .WIDTH       (640),
        .HEIGHT      (480),
        .FRAC        (8),
        .THRUST_SHIFT(10),
        .MAX_V       (1024)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .theta    (theta),
        .B        (B),
        .collision(collision),
        .sin_val  (sin_val),
        .cos_val  (cos_val),
        .topLeft_x(topLeft_x),
        .topLeft_y(topLeft_y)
    );

    typedef struct {
        logic [9:0] theta;
        int         exp_sin;
        int         exp_cos;
        int         tol;
    } trig_vec_t;

    trig_vec_t trig_tbl[9];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    task automatic check(input string name, input int actual, input int expected, input int tol);
        n_tests++;
        if (actual > expected + tol || actual < expected - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at edge %0d",
                     name, actual, expected, tol, edge_n);
        end
    endtask

    task automatic check_pos(input string name, input int ex, input int ey);
        check({name, " x"}, int'(topLeft_x), ex, 0);
        check({name, " y"}, int'(topLeft_y), ey, 0);
    endtask

    task automatic check_trig(input string name, input int es, input int ec, input int tol);
        check({name, " sin"}, $signed(sin_val), es, tol);
        check({name, " cos"}, $signed(cos_val), ec, tol);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    // Holds reset for n edges; the last of them becomes edge 0.
    task automatic do_reset(input int n);
        reset     = 1'b1;
        B         = 1'b0;
        collision = 1'b0;
        repeat (n) step();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        trig_tbl[0] = '{10'd0,    0,      65536,  0};
        trig_tbl[1] = '{10'd256,  65536,  0,      0};
        trig_tbl[2] = '{10'd512,  0,      -65536, 0};
        trig_tbl[3] = '{10'd768,  -65536, 0,      0};
        trig_tbl[4] = '{10'd100,  37735,  53581,  1};
        trig_tbl[5] = '{10'd356,  53581,  -37735, 1};
        trig_tbl[6] = '{10'd612,  -37735, -53581, 1};
        trig_tbl[7] = '{10'd924,  -37735, 53581,  1};
        trig_tbl[8] = '{10'd1023, -402,   65535,  1};

        reset     = 1'b1;
        B         = 1'b0;
        collision = 1'b0;
        theta     = 10'd256;

        // Reset state and idle hold
        do_reset(2);
        check_pos("reset", 320, 240);
        check_trig("reset", 0, 0, 0);
        run_to(1);
        check_trig("first lookup", 65536, 0, 0);
        run_to(20);
        check_pos("idle hold", 320, 240);

        // Trig table, one cycle after each theta
        foreach (trig_tbl[i]) begin
            theta = trig_tbl[i].theta;
            step();
            check_trig($sformatf("theta=%0d", trig_tbl[i].theta),
                       trig_tbl[i].exp_sin, trig_tbl[i].exp_cos, trig_tbl[i].tol);
        end

        // One pulse at theta=0: vx=64, 0.25 px per tick
        theta = 10'd0;
        do_reset(2);
        run_to(1);
        B = 1'b1;
        run_to(2);
        B = 1'b0;
        run_to(9);
        check_pos("pulse x 3 ticks", 320, 240);
        run_to(10);
        check_pos("pulse x 4 ticks", 321, 240);

        // Up then cancel: theta=256 pulse, then theta=768 pulse
        theta = 10'd256;
        do_reset(2);
        run_to(1);
        B = 1'b1;
        run_to(2);
        B = 1'b0;
        run_to(4);
        check_pos("up first tick", 320, 239);
        run_to(10);
        check_pos("up 4 ticks", 320, 239);
        run_to(12);
        check_pos("up 5 ticks", 320, 238);
        theta = 10'd768;
        run_to(13);
        B = 1'b1;
        run_to(14);
        B = 1'b0;
        check_pos("cancel edge", 320, 238);
        run_to(30);
        check_pos("cancelled drift", 320, 238);

        // Left wrap: four pulses at theta=512, vx=-256 (1 px per tick)
        theta = 10'd512;
        do_reset(2);
        run_to(1);
        B = 1'b1;
        run_to(5);
        B = 1'b0;
        run_to(6);
        check_pos("left ramp", 318, 240);
        run_to(642);
        check_pos("left edge", 0, 240);
        run_to(644);
        check_pos("left wrap", 639, 240);
        run_to(646);
        check_pos("left after wrap", 638, 240);

        // Saturation and right wrap: 20 pulses at theta=0
        theta = 10'd0;
        do_reset(2);
        run_to(1);
        B = 1'b1;
        run_to(16);
        check_pos("ramp", 334, 240);
        run_to(18);
        check_pos("sat tick 1", 338, 240);
        run_to(20);
        check_pos("sat tick 2", 342, 240);
        run_to(21);
        B = 1'b0;
        run_to(22);
        check_pos("sat tick 3", 346, 240);
        run_to(168);
        check_pos("right edge", 638, 240);
        run_to(170);
        check_pos("right wrap", 2, 240);
        run_to(172);
        check_pos("right after wrap", 6, 240);

        // Collision mid-flight
        collision = 1'b1;
        run_to(173);
        collision = 1'b0;
        check_pos("collision", 320, 240);
        check("collision keeps cos", $signed(cos_val), 65536, 0);
        run_to(185);
        check_pos("after collision", 320, 240);

        // New velocity, then reset mid-flight
        B = 1'b1;
        run_to(189);
        B = 1'b0;
        run_to(200);
        check_pos("regain", 326, 240);
        do_reset(1);
        check_pos("mid reset", 320, 240);
        check_trig("mid reset", 0, 0, 0);
        run_to(1);
        check_trig("lookup after reset", 0, 65536, 0);
        run_to(12);
        check_pos("after mid reset", 320, 240);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
